// File: rtl/ftoi_pipe.sv
// rtl/ftoi_pipe.sv - pipelined binary32 to signed integer converter with rounding modes
// Stages: decode/shift, round, saturate; LATENCY selects how many are registered.
module ftoi_pipe #(
  parameter int INT_WIDTH = 32,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          src,
  input  logic [1:0]           rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WIDTH-1:0] dest,
  output logic                 ovf,
  output logic                 inv,
  output logic                 inexact
);

  localparam int W   = INT_WIDTH;
  localparam int XW  = W + 24;
  localparam int S1W = W + 7;
  localparam int S2W = W + 5;

  localparam logic [W:0]   POS_LIM = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0]   NEG_LIM = {2'b01, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_INT = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  // The whole pipe advances together, so a stall freezes every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1 bundle: {sign, nan, big, rm[1:0], guard, sticky, mag[W-1:0]}
  logic [S1W-1:0] a1;
  always_comb begin
    logic [7:0]        expf;
    logic signed [9:0] e;
    logic [6:0]        sh;
    logic [XW-1:0]     x;
    logic              nan, big, g, s;
    logic [W-1:0]      mag;
    expf = src[30:23];
    e    = $signed({2'b00, expf}) - 10'sd127;
    nan  = 1'b0;
    big  = 1'b0;
    g    = 1'b0;
    s    = 1'b0;
    mag  = '0;
    x    = '0;
    sh   = '0;
    if (expf == 8'hFF) begin
      nan = |src[22:0];
      big = ~|src[22:0];
    end else if (expf != 8'h00) begin
      // Anything at or above 2^W overflows regardless of rounding, so the shift never exceeds W.
      if (e >= $signed(10'(W))) begin
        big = 1'b1;
      end else if (e < -10'sd1) begin
        s = 1'b1;
      end else begin
        sh  = 7'(e + 10'sd1);
        x   = XW'({1'b1, src[22:0]}) << sh;
        mag = x[24 +: W];
        g   = x[23];
        s   = |x[22:0];
      end
    end
    a1 = {src[31], nan, big, rm, g, s, mag};
  end

  logic [S1W-1:0] b1;
  logic           b1_valid;
  generate
    if (LATENCY >= 2) begin : g_r1
      logic [S1W-1:0] q;
      logic           v;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
          v <= 1'b0;
        end else if (advance) begin
          v <= in_valid;
          if (in_valid) q <= a1;
        end
      end
      assign b1       = q;
      assign b1_valid = v;
    end else begin : g_c1
      assign b1       = a1;
      assign b1_valid = in_valid;
    end
  endgenerate

  // S2 bundle: {sign, nan, big, inexact, rmag[W:0]}
  logic [S2W-1:0] a2;
  always_comb begin
    logic         sign, inx, inc;
    logic [W:0]   rmag;
    sign = b1[W+6];
    inx  = b1[W+1] | b1[W];
    inc  = 1'b0;
    case (b1[W+3:W+2])
      2'b00:   inc = b1[W+1];
      2'b01:   inc = 1'b0;
      2'b10:   inc = sign & inx;
      default: inc = !sign & inx;
    endcase
    rmag = {1'b0, b1[W-1:0]} + (W+1)'(inc);
    a2   = {sign, b1[W+5], b1[W+4], inx, rmag};
  end

  logic [S2W-1:0] b2;
  logic           b2_valid;
  generate
    if (LATENCY >= 3) begin : g_r2
      logic [S2W-1:0] q;
      logic           v;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
          v <= 1'b0;
        end else if (advance) begin
          v <= b1_valid;
          if (b1_valid) q <= a2;
        end
      end
      assign b2       = q;
      assign b2_valid = v;
    end else begin : g_c2
      assign b2       = a2;
      assign b2_valid = b1_valid;
    end
  endgenerate

  logic [W-1:0] r_dest;
  logic         r_ovf, r_inv, r_inx;
  always_comb begin
    logic       sign;
    logic [W:0] rmag;
    sign   = b2[W+4];
    rmag   = b2[W:0];
    r_dest = '0;
    r_ovf  = 1'b0;
    r_inv  = 1'b0;
    r_inx  = 1'b0;
    if (b2[W+3]) begin
      r_dest = MAX_INT;
      r_inv  = 1'b1;
    end else if (b2[W+2] || (sign ? (rmag > NEG_LIM) : (rmag > POS_LIM))) begin
      r_dest = sign ? MIN_INT : MAX_INT;
      r_ovf  = 1'b1;
    end else begin
      r_dest = sign ? (~rmag[W-1:0] + 1'b1) : rmag[W-1:0];
      r_inx  = b2[W+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dest      <= '0;
      ovf       <= 1'b0;
      inv       <= 1'b0;
      inexact   <= 1'b0;
    end else if (advance) begin
      out_valid <= b2_valid;
      if (b2_valid) begin
        dest    <= r_dest;
        ovf     <= r_ovf;
        inv     <= r_inv;
        inexact <= r_inx;
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb/tb_ftoi_pipe.sv - scoreboard bench for ftoi_pipe, one instance per LATENCY 1..3
// All instances share stimulus; each consumes the expected-result queue at its own read index.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] src = '0;
  logic [1:0]  rm = '0;
  logic [2:0]  in_ready, out_valid, ovf, inv, inexact;
  logic [31:0] dest [3];

  int n_chk = 0;
  int n_fail = 0;

  logic [34:0] exp_q [$];
  int          rd [3];
  int          out_cnt [3];
  logic [2:0]  hold_prev = '0;
  logic [34:0] hold_val [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ftoi_pipe #(.INT_WIDTH(32), .LATENCY(g + 1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
      .src(src), .rm(rm), .out_valid(out_valid[g]), .out_ready(out_ready),
      .dest(dest[g]), .ovf(ovf[g]), .inv(inv[g]), .inexact(inexact[g])
    );
  end

  function automatic logic [34:0] model(input logic [31:0] s, input logic [1:0] m);
    logic   neg, inx;
    int     ex;
    real    mag, fl, fr;
    longint t;
    logic [31:0] sat;
    neg = s[31];
    ex  = int'(s[30:23]);
    sat = neg ? 32'h80000000 : 32'h7FFFFFFF;
    if (ex == 0) return 35'd0;
    if (ex == 255) begin
      if (s[22:0] != 23'd0) return {32'h7FFFFFFF, 3'b010};
      return {sat, 3'b100};
    end
    mag = (8388608.0 + real'(s[22:0])) * (2.0 ** (ex - 150));
    if (mag >= 4294967296.0) return {sat, 3'b100};
    fl  = $floor(mag);
    fr  = mag - fl;
    t   = longint'(fl);
    inx = fr > 0.0;
    case (m)
      2'b00: if (fr >= 0.5) t = t + 1;
      2'b10: if (neg && inx) t = t + 1;
      2'b11: if (!neg && inx) t = t + 1;
      default: ;
    endcase
    if ((!neg && t > 64'sd2147483647) || (neg && t > 64'sd2147483648)) return {sat, 3'b100};
    return {neg ? 32'(-t) : 32'(t), 2'b00, inx};
  endfunction

  always @(negedge clk) begin
    logic [34:0] got;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        got = {dest[k], ovf[k], inv[k], inexact[k]};
        n_chk++;
        if (in_ready[k] !== (!out_valid[k] || out_ready)) begin
          n_fail++;
          $display("FAIL in_ready L%0d: got %b required %b", k + 1, in_ready[k], !out_valid[k] || out_ready);
        end
        if (out_valid[k] && out_ready) begin
          n_chk++;
          if (rd[k] >= exp_q.size()) begin
            n_fail++;
            $display("FAIL unexpected_output L%0d: got %h with no pending expectation", k + 1, got);
          end else begin
            if (got !== exp_q[rd[k]]) begin
              n_fail++;
              $display("FAIL scoreboard L%0d: got %h required %h", k + 1, got, exp_q[rd[k]]);
            end
            rd[k]++;
            out_cnt[k]++;
          end
        end
        if (out_valid[k] && !out_ready) begin
          if (hold_prev[k]) begin
            n_chk++;
            if (got !== hold_val[k]) begin
              n_fail++;
              $display("FAIL stall_hold L%0d: got %h required %h", k + 1, got, hold_val[k]);
            end
          end
          hold_prev[k] = 1'b1;
          hold_val[k]  = got;
        end else begin
          hold_prev[k] = 1'b0;
        end
      end
      while (rd[0] > 0 && rd[1] > 0 && rd[2] > 0) begin
        exp_q.delete(0);
        for (int k = 0; k < 3; k++) rd[k]--;
      end
    end
  end

  task automatic send(input logic [31:0] s, input logic [1:0] m, input logic [34:0] e);
    int guard;
    src = s;
    rm = m;
    in_valid = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!(&in_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready %b required 111", in_ready);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({out_valid[k], dest[k], ovf[k], inv[k], inexact[k]} !== 36'd0) begin
        n_fail++;
        $display("FAIL reset_outputs L%0d: got %b/%h/%b%b%b required all zero", k + 1,
                 out_valid[k], dest[k], ovf[k], inv[k], inexact[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 3'b111 || out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: in_ready %b out_valid %b required 111 000", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    send(32'h3FC00000, 2'b00, {32'h00000002, 3'b001});
    send(32'h3FC00000, 2'b01, {32'h00000001, 3'b001});
    send(32'h3FC00000, 2'b10, {32'h00000001, 3'b001});
    send(32'h3FC00000, 2'b11, {32'h00000002, 3'b001});
    send(32'hBFC00000, 2'b00, {32'hFFFFFFFE, 3'b001});
    send(32'hBFC00000, 2'b01, {32'hFFFFFFFF, 3'b001});
    send(32'hBFC00000, 2'b10, {32'hFFFFFFFE, 3'b001});
    send(32'hBFC00000, 2'b11, {32'hFFFFFFFF, 3'b001});
    send(32'h4F000000, 2'b00, {32'h7FFFFFFF, 3'b100});
    send(32'hCF000000, 2'b00, {32'h80000000, 3'b000});
    send(32'hCF000000, 2'b11, {32'h80000000, 3'b000});
    send(32'hCF000001, 2'b11, {32'h80000000, 3'b100});
    send(32'hFF800000, 2'b01, {32'h80000000, 3'b100});
    send(32'h7F800000, 2'b00, {32'h7FFFFFFF, 3'b100});
    send(32'h7FC00000, 2'b00, {32'h7FFFFFFF, 3'b010});
    for (int m = 0; m < 4; m++) send(32'h00000001, 2'(m), 35'd0);
    send(32'hBF000000, 2'b10, {32'hFFFFFFFF, 3'b001});
    send(32'h3F000000, 2'b00, {32'h00000001, 3'b001});
    send(32'h3F000000, 2'b01, {32'h00000000, 3'b001});
    send(32'h4EFFFFFF, 2'b00, {32'h7FFFFF80, 3'b000});
    send(32'h80000000, 2'b10, 35'd0);
    drain();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL directed_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back_stall();
    for (int k = 0; k < 3; k++) out_cnt[k] = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [31:0] s;
          s = 32'h41000000 + 32'(i * 32'h00080000) + (i[0] ? 32'h80000000 : 32'h0);
          send(s, 2'(i), model(s, 2'(i)));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (out_cnt[k] != 20) begin
        n_fail++;
        $display("FAIL stream_count L%0d: got %0d required 20", k + 1, out_cnt[k]);
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    int lat [3];
    out_ready = 1'b1;
    send(32'h40400000, 2'b00, model(32'h40400000, 2'b00));
    send(32'hC0A00000, 2'b01, model(32'hC0A00000, 2'b01));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (out_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_async L%0d: out_valid %b required 0", k + 1, out_valid[k]);
      end
    end
    exp_q.delete();
    for (int k = 0; k < 3; k++) rd[k] = 0;
    hold_prev = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_dropped: out_valid %b required 000", out_valid);
      end
    end
    @(posedge clk);
    #1;
    src = 32'h42280000;
    rm = 2'b00;
    in_valid = 1'b1;
    @(negedge clk);
    exp_q.push_back({32'h0000002A, 3'b000});
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 3; k++) lat[k] = 0;
    for (int c = 1; c <= 5; c++) begin
      for (int k = 0; k < 3; k++) if (out_valid[k] && lat[k] == 0) lat[k] = c;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (lat[k] != k + 1) begin
        n_fail++;
        $display("FAIL latency L%0d: got %0d required %0d", k + 1, lat[k], k + 1);
      end
    end
    drain();
  endtask

  task automatic test_random_sweep();
    logic [31:0] r, s;
    for (int e = 1; e <= 254; e++) begin
      for (int i = 0; i < 24; i++) begin
        r = $urandom();
        s = {r[31], 8'(e), r[22:0]};
        for (int m = 0; m < 4; m++) send(s, 2'(m), model(s, 2'(m)));
      end
    end
    drain();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rd[k] = 0;
      out_cnt[k] = 0;
      hold_val[k] = '0;
    end
    test_reset();
    test_directed();
    test_back_to_back_stall();
    test_reset_inflight();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
